// File: rtl/pll_reconfig_sequencer.sv
// Arbitrates two requesters onto the altpll_reconfig port and rewrites the PLL N/M counters.
// Optional lock watchdog: define PLL_LOCK_TIMEOUT_EN (limit set by LOCK_TIMEOUT).
module pll_reconfig_sequencer #(
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [31:0] req_data,
   output logic [1:0]  ack,
   output logic [1:0]  err,
   output logic [1:0]  grant,
   output logic        seq_busy,
   output logic [3:0]  counter_type,
   output logic [2:0]  counter_param,
   output logic [8:0]  data_in,
   output logic        write_param,
   output logic        reconfig,
   input  logic        rcfg_busy,
   input  logic        locked
);

   typedef enum logic [3:0] {
      IDLE, ARB, CHECK, WRITE, WAIT_W, RECONF, WAIT_R, WAIT_LOCK, DONE, FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] word_q, word_d;
   logic [2:0]  idx_q, idx_d;
   logic        blank_q, blank_d;
   logic        gsel_q, gsel_d;
   logic        last_q, last_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  ack_q, ack_d;
   logic [1:0]  err_q, err_d;
   logic        seq_busy_q, seq_busy_d;
   logic        write_param_q, write_param_d;
   logic        reconfig_q, reconfig_d;
   logic [3:0]  ctype_q, ctype_d;
   logic [2:0]  cparam_q, cparam_d;
   logic [8:0]  data_q, data_d;
   logic        winner;
   logic [7:0]  factor;

`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [16:0] LOCK_LIMIT = 17'(LOCK_TIMEOUT);
   logic [15:0] lock_cnt_q, lock_cnt_d;
`endif

   // Counter value for one parameter slot: 0 high, 1 low, 2 bypass, 3 odd.
   function automatic logic [8:0] param_value(input logic [7:0] f, input logic [1:0] slot);
      logic [8:0] v;
      v = '0;
      case (slot)
         2'd0:    v = ({1'b0, f} + 9'd1) >> 1;
         2'd1:    v = (f == 8'd1) ? 9'd1 : {2'b00, f[7:1]};
         2'd2:    v = {8'd0, (f == 8'd1)};
         default: v = {8'd0, f[0]};
      endcase
      return v;
   endfunction

   // NOTE: every variable gets a default at the top of the block, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      word_d        = word_q;
      idx_d         = idx_q;
      blank_d       = 1'b0;
      gsel_d        = gsel_q;
      last_d        = last_q;
      grant_d       = grant_q;
      seq_busy_d    = seq_busy_q;
      ctype_d       = ctype_q;
      cparam_d      = cparam_q;
      data_d        = data_q;
      write_param_d = 1'b0;
      reconfig_d    = 1'b0;
      ack_d         = 2'b00;
      err_d         = 2'b00;
      winner        = (req == 2'b11) ? ~last_q : req[1];
`ifdef PLL_LOCK_TIMEOUT_EN
      lock_cnt_d    = lock_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (req != 2'b00) state_d = ARB;
         end
         ARB: begin
            if (req == 2'b00) begin
               state_d = IDLE;
            end else begin
               gsel_d     = winner;
               word_d     = winner ? req_data[31:16] : req_data[15:0];
               grant_d    = winner ? 2'b10 : 2'b01;
               seq_busy_d = 1'b1;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            if (word_q[15:8] == 8'd0 || word_q[7:0] == 8'd0) begin
               state_d = FAIL;
            end else begin
               idx_d   = 3'd0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            blank_d = 1'b1;
            state_d = WAIT_W;
         end
         WAIT_W: begin
            // The reconfig block raises busy one cycle after the strobe, so the
            // first cycle here is blind.
            if (!blank_q && !rcfg_busy) begin
               if (idx_q == 3'd7) begin
                  state_d = RECONF;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = WRITE;
               end
            end
         end
         RECONF: begin
            blank_d = 1'b1;
            state_d = WAIT_R;
         end
         WAIT_R: begin
            if (!blank_q && !rcfg_busy) begin
               state_d = WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
               lock_cnt_d = 16'd0;
`endif
            end
         end
         WAIT_LOCK: begin
            if (locked) begin
               state_d = DONE;
`ifdef PLL_LOCK_TIMEOUT_EN
            end else if ({1'b0, lock_cnt_q} + 17'd1 == LOCK_LIMIT) begin
               state_d = FAIL;
            end else begin
               lock_cnt_d = lock_cnt_q + 16'd1;
`endif
            end
         end
         DONE, FAIL: begin
            grant_d    = 2'b00;
            seq_busy_d = 1'b0;
            last_d     = gsel_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered off the next state so they coincide with it.
      factor        = idx_d[2] ? word_q[15:8] : word_q[7:0];
      write_param_d = (state_d == WRITE);
      reconfig_d    = (state_d == RECONF);
      if (state_d == WRITE) begin
         ctype_d  = {3'b000, idx_d[2]};
         cparam_d = {idx_d[1], 1'b0, idx_d[0]};
         data_d   = param_value(factor, idx_d[1:0]);
      end
      if (state_d == DONE) ack_d = gsel_q ? 2'b10 : 2'b01;
      if (state_d == FAIL) err_d = gsel_q ? 2'b10 : 2'b01;
   end

   // NOTE: state registers take non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         word_q        <= '0;
         idx_q         <= '0;
         blank_q       <= 1'b0;
         gsel_q        <= 1'b0;
         last_q        <= 1'b1;
         grant_q       <= 2'b00;
         ack_q         <= 2'b00;
         err_q         <= 2'b00;
         seq_busy_q    <= 1'b0;
         write_param_q <= 1'b0;
         reconfig_q    <= 1'b0;
         ctype_q       <= '0;
         cparam_q      <= '0;
         data_q        <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
         lock_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         idx_q         <= idx_d;
         blank_q       <= blank_d;
         gsel_q        <= gsel_d;
         last_q        <= last_d;
         grant_q       <= grant_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         seq_busy_q    <= seq_busy_d;
         write_param_q <= write_param_d;
         reconfig_q    <= reconfig_d;
         ctype_q       <= ctype_d;
         cparam_q      <= cparam_d;
         data_q        <= data_d;
`ifdef PLL_LOCK_TIMEOUT_EN
         lock_cnt_q    <= lock_cnt_d;
`endif
      end
   end

   assign ack           = ack_q;
   assign err           = err_q;
   assign grant         = grant_q;
   assign seq_busy      = seq_busy_q;
   assign counter_type  = ctype_q;
   assign counter_param = cparam_q;
   assign data_in       = data_q;
   assign write_param   = write_param_q;
   assign reconfig      = reconfig_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer with a behavioural reconfig-block/PLL model.
`timescale 1ns/1ps
module tb_pll_reconfig_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [31:0] req_data = '0;
   logic [1:0]  ack, err, grant;
   logic        seq_busy, write_param, reconfig;
   logic [3:0]  counter_type;
   logic [2:0]  counter_param;
   logic [8:0]  data_in;
   logic        rcfg_busy = 1'b0;
   logic        locked = 1'b1;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_w[$];   // {counter_type, counter_param, data_in}
   logic [3:0]  exp_r[$];   // {ack, err}
   logic [15:0] mon_w;
   logic [3:0]  mon_r;

   logic wp_seen = 1'b0, rc_seen = 1'b0, lock_hold = 1'b0, lock_arm = 1'b0;
   int   busy_cnt = 0, lock_cnt = 0;

   pll_reconfig_sequencer #(.LOCK_TIMEOUT(100)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .err(err), .grant(grant), .seq_busy(seq_busy),
      .counter_type(counter_type), .counter_param(counter_param), .data_in(data_in),
      .write_param(write_param), .reconfig(reconfig),
      .rcfg_busy(rcfg_busy), .locked(locked)
   );

   always #5 clock = ~clock;

   // Reconfig block: busy for 4 cycles after each strobe. PLL: unlocks on reconfig,
   // relocks 10 cycles after the block goes idle unless lock_hold is set.
   initial forever begin
      @(negedge clock);
      wp_seen = write_param;
      rc_seen = reconfig;
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (wp_seen || rc_seen) busy_cnt = 4;
      else if (busy_cnt > 0) busy_cnt--;
      rcfg_busy = (busy_cnt != 0);
      if (rc_seen) begin
         locked = 1'b0; lock_arm = 1'b1; lock_cnt = 0;
      end else if (lock_arm && busy_cnt == 0) begin
         lock_cnt++;
         if (lock_cnt >= 10 && !lock_hold) begin
            locked = 1'b1; lock_arm = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (write_param) begin
            checks++;
            if (exp_w.size() == 0) begin
               failures++;
               $display("FAIL write_unexpected got ct=%0h cp=%0h d=%0d expected no write",
                        counter_type, counter_param, data_in);
            end else begin
               mon_w = exp_w.pop_front();
               if ({counter_type, counter_param, data_in} !== mon_w) begin
                  failures++;
                  $display("FAIL write_value got ct=%0h cp=%0h d=%0d expected ct=%0h cp=%0h d=%0d",
                           counter_type, counter_param, data_in, mon_w[15:12], mon_w[11:9], mon_w[8:0]);
               end
            end
         end
         if ((ack | err) != 2'b00) begin
            checks++;
            if (exp_r.size() == 0) begin
               failures++;
               $display("FAIL resp_unexpected got ack=%b err=%b expected none", ack, err);
            end else begin
               mon_r = exp_r.pop_front();
               if ({ack, err} !== mon_r) begin
                  failures++;
                  $display("FAIL resp_value got ack=%b err=%b expected ack=%b err=%b",
                           ack, err, mon_r[3:2], mon_r[1:0]);
               end
            end
         end
      end
   end

   function automatic logic [8:0] model_val(input logic [7:0] f, input int slot);
      int fi;
      fi = int'(f);
      case (slot)
         0:       return 9'((fi + 1) / 2);
         1:       return 9'((fi == 1) ? 1 : fi / 2);
         2:       return 9'((fi == 1) ? 1 : 0);
         default: return 9'(fi % 2);
      endcase
   endfunction

   task automatic push_writes(input logic [15:0] word);
      logic [7:0] f;
      logic [2:0] cp;
      for (int k = 0; k < 8; k++) begin
         f = (k < 4) ? word[7:0] : word[15:8];
         case (k % 4)
            0: cp = 3'b000;
            1: cp = 3'b001;
            2: cp = 3'b100;
            default: cp = 3'b101;
         endcase
         exp_w.push_back({(k < 4) ? 4'b0000 : 4'b0001, cp, model_val(f, k % 4)});
      end
   endtask

   task automatic push_const(input logic [3:0] ct, input logic [2:0] cp, input int d);
      exp_w.push_back({ct, cp, 9'(d)});
   endtask

   task automatic set_word(input int r, input logic [15:0] word);
      if (r == 0) req_data[15:0] = word;
      else        req_data[31:16] = word;
   endtask

   task automatic wait_resp(input int r, output int n_wr, output int n_rc);
      bit seen;
      seen = 1'b0; n_wr = 0; n_rc = 0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(negedge clock);
         if (write_param) n_wr++;
         if (reconfig) n_rc++;
         if (ack[r] || err[r]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL resp_timeout requester=%0d got no ack/err expected one within 1000 cycles", r);
      end
   endtask

   task automatic serve(input int r, input logic [15:0] word, output int n_wr, output int n_rc);
      set_word(r, word);
      req[r] = 1'b1;
      wait_resp(r, n_wr, n_rc);
      req[r] = 1'b0;
      @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (grant !== 2'b00)      begin failures++; $display("FAIL rst_grant got %b expected 00", grant); end
      checks++; if ({ack, err} !== 4'b0)  begin failures++; $display("FAIL rst_ack_err got %b expected 0000", {ack, err}); end
      checks++; if (seq_busy !== 1'b0)    begin failures++; $display("FAIL rst_seq_busy got %b expected 0", seq_busy); end
      checks++; if ({write_param, reconfig} !== 2'b00) begin failures++; $display("FAIL rst_strobes got %b expected 00", {write_param, reconfig}); end
      checks++; if ({counter_type, counter_param, data_in} !== 16'h0) begin failures++; $display("FAIL rst_fields got %h expected 0000", {counter_type, counter_param, data_in}); end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (grant !== 2'b00)      begin failures++; $display("FAIL idle_grant got %b expected 00", grant); end
   endtask

   task automatic test_basic_write();
      int n_wr, n_rc;
      push_const(4'b0000, 3'b000, 1); push_const(4'b0000, 3'b001, 1);
      push_const(4'b0000, 3'b100, 0); push_const(4'b0000, 3'b101, 0);
      push_const(4'b0001, 3'b000, 3); push_const(4'b0001, 3'b001, 2);
      push_const(4'b0001, 3'b100, 0); push_const(4'b0001, 3'b101, 1);
      exp_r.push_back({2'b01, 2'b00});
      set_word(0, 16'h0502);
      req[0] = 1'b1;
      @(negedge clock);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL grant_early got %b expected 00", grant); end
      @(negedge clock);
      checks++; if ({grant, seq_busy} !== 3'b011) begin failures++; $display("FAIL grant_latency got grant=%b busy=%b expected grant=01 busy=1", grant, seq_busy); end
      wait_resp(0, n_wr, n_rc);
      checks++; if ({grant, seq_busy} !== 3'b011) begin failures++; $display("FAIL busy_at_ack got grant=%b busy=%b expected grant=01 busy=1", grant, seq_busy); end
      req[0] = 1'b0;
      @(negedge clock);
      checks++; if ({grant, seq_busy, ack} !== 5'b0) begin failures++; $display("FAIL after_ack got grant=%b busy=%b ack=%b expected all 0", grant, seq_busy, ack); end
      checks++; if (n_wr !== 8) begin failures++; $display("FAIL basic_writes got %0d expected 8", n_wr); end
      checks++; if (n_rc !== 1) begin failures++; $display("FAIL basic_reconfig got %0d expected 1", n_rc); end
   endtask

   task automatic test_bypass();
      int n_wr, n_rc;
      push_const(4'b0000, 3'b000, 2); push_const(4'b0000, 3'b001, 1);
      push_const(4'b0000, 3'b100, 0); push_const(4'b0000, 3'b101, 1);
      push_const(4'b0001, 3'b000, 1); push_const(4'b0001, 3'b001, 1);
      push_const(4'b0001, 3'b100, 1); push_const(4'b0001, 3'b101, 1);
      exp_r.push_back({2'b10, 2'b00});
      serve(1, 16'h0103, n_wr, n_rc);
      checks++; if (n_rc !== 1) begin failures++; $display("FAIL bypass_reconfig got %0d expected 1", n_rc); end
   endtask

   task automatic test_zero_factor();
      int n_wr, n_rc;
      exp_r.push_back({2'b00, 2'b01});
      serve(0, 16'h0004, n_wr, n_rc);
      checks++; if ({n_wr, n_rc} !== {32'd0, 32'd0}) begin failures++; $display("FAIL zero_m_strobes got writes=%0d reconfig=%0d expected 0 0", n_wr, n_rc); end
      exp_r.push_back({2'b00, 2'b10});
      serve(1, 16'h0500, n_wr, n_rc);
      checks++; if (n_wr !== 0) begin failures++; $display("FAIL zero_n_writes got %0d expected 0", n_wr); end
   endtask

   task automatic test_round_robin();
      int n_wr, n_rc;
      pulse_reset();
      push_writes(16'h0302);
      push_writes(16'h0205);
      exp_r.push_back({2'b01, 2'b00});
      exp_r.push_back({2'b10, 2'b00});
      req_data = {16'h0205, 16'h0302};
      req = 2'b11;
      wait_resp(0, n_wr, n_rc);
      checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rr_first got ack=%b expected 01", ack); end
      req[0] = 1'b0;
      wait_resp(1, n_wr, n_rc);
      checks++; if ({grant, ack} !== 4'b1010) begin failures++; $display("FAIL rr_second got grant=%b ack=%b expected 10 10", grant, ack); end
      checks++; if (n_wr !== 8) begin failures++; $display("FAIL rr_second_writes got %0d expected 8", n_wr); end
      req[1] = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_factor_sweep();
      int n_wr, n_rc;
      logic [15:0] word;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: word = 16'hFFFF;
            1: word = 16'h0101;
            default: word = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
         endcase
         push_writes(word);
         exp_r.push_back({(i % 2 == 0) ? 2'b01 : 2'b10, 2'b00});
         serve(i % 2, word, n_wr, n_rc);
         checks++; if (n_wr !== 8) begin failures++; $display("FAIL sweep_writes word=%h got %0d expected 8", word, n_wr); end
      end
   endtask

   task automatic test_reset_mid();
      int n_wr, n_rc, stray;
      push_writes(16'h0706);
      set_word(0, 16'h0706);
      req[0] = 1'b1;
      n_wr = 0;
      for (int c = 0; c < 1000 && n_wr < 5; c++) begin
         @(negedge clock);
         if (write_param) n_wr++;
      end
      checks++; if (n_wr !== 5) begin failures++; $display("FAIL mid_reach_write5 got %0d expected 5", n_wr); end
      reset = 1'b1;
      req = 2'b00;
      exp_w.delete();
      @(negedge clock);
      checks++; if ({grant, ack, err, seq_busy} !== 7'b0) begin failures++; $display("FAIL mid_rst_status got %b expected 0000000", {grant, ack, err, seq_busy}); end
      checks++; if ({write_param, reconfig, counter_type, counter_param, data_in} !== 18'b0) begin failures++; $display("FAIL mid_rst_port got %h expected 0", {write_param, reconfig, counter_type, counter_param, data_in}); end
      @(negedge clock);
      reset = 1'b0;
      stray = 0;
      repeat (30) begin
         @(negedge clock);
         if ((ack | err) != 2'b00) stray++;
      end
      checks++; if (stray !== 0) begin failures++; $display("FAIL mid_no_resp got %0d responses expected 0", stray); end
      push_writes(16'h0403);
      exp_r.push_back({2'b01, 2'b00});
      serve(0, 16'h0403, n_wr, n_rc);
      checks++; if ({n_wr, n_rc} !== {32'd8, 32'd1}) begin failures++; $display("FAIL mid_fresh got writes=%0d reconfig=%0d expected 8 1", n_wr, n_rc); end
   endtask

`ifdef PLL_LOCK_TIMEOUT_EN
   task automatic test_lock_timeout();
      int n, n_wr, n_rc;
      bit seen;
      lock_hold = 1'b1;
      push_writes(16'h0302);
      exp_r.push_back({2'b00, 2'b01});
      set_word(0, 16'h0302);
      req[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(negedge clock);
         if (reconfig) seen = 1'b1;
      end
      // WAIT_LOCK begins 6 cycles after the reconfig pulse with this block model.
      n = 0;
      for (int c = 0; c < 400 && seen; c++) begin
         @(negedge clock);
         n++;
         if (err[0]) break;
      end
      checks++; if (n !== 106) begin failures++; $display("FAIL lock_timeout got %0d cycles after reconfig expected 106", n); end
      req[0] = 1'b0;
      lock_hold = 1'b0;
      repeat (3) @(negedge clock);
      n_wr = 0; n_rc = 0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no completion expected finish before 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clock);
      test_reset();
      test_basic_write();
      test_bypass();
      test_zero_factor();
      test_round_robin();
      test_factor_sweep();
      test_reset_mid();
`ifdef PLL_LOCK_TIMEOUT_EN
      test_lock_timeout();
`endif
      repeat (5) @(negedge clock);
      checks++;
      if (exp_w.size() != 0 || exp_r.size() != 0) begin
         failures++;
         $display("FAIL leftover got writes=%0d resps=%0d expected 0 0", exp_w.size(), exp_r.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
